// File: rtl/led_pwm_fader.sv
// ----------------------------------------------------------------------------
// led_pwm_fader
//   PWM output stage for a 3-LED rotating pattern. It takes the active-low
//   pattern from the upstream counter and drives each LED with a PWM duty.
//   When a channel's on/off state changes, its duty ramps by one LSB per step
//   tick from its current value toward the new level. A rotation therefore
//   becomes a crossfade instead of a hard step.
//
// Ports
//   sys_clk     in   1         system clock, rising edge
//   sys_rst     in   1         synchronous active-high reset
//   enable      in   1         1 = run; 0 = LEDs dark, duties and step timer cleared
//   brightness  in   PWM_BITS  duty applied to a channel that is on
//   led_in      in   3         pattern from upstream, active-low (0 = on)
//   led_out     out  3         PWM LED drive, active-low (0 = lit)
//   busy        out  1         high while any channel is still ramping
// ----------------------------------------------------------------------------
module led_pwm_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 24000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [2:0]          led_in,
    output logic [2:0]          led_out,
    output logic                busy
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          led_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_tick;
    logic [PWM_BITS-1:0] duty      [3];
    logic [PWM_BITS-1:0] target    [3];
    logic [PWM_BITS-1:0] duty_step [3];
    logic [2:0]          lit;
    logic                settled;

    assign step_tick = (step_cnt == STEP_LAST);
    assign busy      = (state == FADE);

    // Per-channel target, the candidate next duty for a step tick, and the
    // raw PWM compare. Each channel moves only one LSB per tick, so it can
    // never pass its target and never wraps.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        settled = 1'b1;
        lit     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            target[i]    = led_q[i] ? '0 : brightness;
            duty_step[i] = duty[i];
            if (duty[i] < target[i]) begin
                duty_step[i] = duty[i] + PWM_BITS'(1);
            end else if (duty[i] > target[i]) begin
                duty_step[i] = duty[i] - PWM_BITS'(1);
            end
            if (duty[i] != target[i]) begin
                settled = 1'b0;
            end
            lit[i] = (pwm_cnt < duty[i]);
        end
    end

    // Next-state logic. The state register only follows it while enabled.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!settled) state_next = FADE;
            FADE:    if (settled)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_q    <= 3'b111;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            led_out  <= 3'b111;
            state    <= IDLE;
            // NOTE: duty is a three-entry register file, not a RAM, so it is
            // cleared here like any other register.
            for (int i = 0; i < 3; i++) begin
                duty[i] <= '0;
            end
        end else begin
            led_q   <= led_in;
            // The PWM counter keeps running while disabled; only the fade
            // machinery is held in its cleared state.
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (!enable) begin
                led_out  <= 3'b111;
                step_cnt <= '0;
                state    <= IDLE;
                for (int i = 0; i < 3; i++) begin
                    duty[i] <= '0;
                end
            end else begin
                step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
                led_out  <= ~lit;
                state    <= state_next;
                if (step_tick) begin
                    for (int i = 0; i < 3; i++) begin
                        duty[i] <= duty_step[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// ----------------------------------------------------------------------------
// tb_led_pwm_fader
//   Directed bench for led_pwm_fader with PWM_BITS=4 and STEP_CYCLES=4.
//   It drives inputs 1 ns after each rising edge and samples outputs at the
//   same point.
// ----------------------------------------------------------------------------
module tb_led_pwm_fader;

    localparam int PB = 4;
    localparam int SC = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          enable;
    logic [PB-1:0] brightness;
    logic [2:0]    led_in;
    logic [2:0]    led_out;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 sys_clk = ~sys_clk;

    led_pwm_fader #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .brightness (brightness),
        .led_in     (led_in),
        .led_out    (led_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag, input logic val, input int max_cycles,
                             output int n);
        n = 0;
        while (busy !== val && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_duty0(input string tag, input int val, input int max_cycles);
        int n;
        n = 0;
        while (int'(dut.duty[0]) != val && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, 32'(dut.duty[0]), 32'(val));
    endtask

    // Counts the cycles in one PWM period where channel ch is lit, and the
    // cycles where either of the other channels is lit.
    task automatic lit_count(input int ch, output int lit, output int others);
        lit    = 0;
        others = 0;
        repeat (1 << PB) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (led_out[i] === 1'b0) begin
                    if (i == ch) lit++;
                    else         others++;
                end
            end
        end
    endtask

    initial begin
        int n, bad, lit, others, prev, changes, p;
        bit seen;

        // 1. Reset for three cycles, then idle for 100 cycles.
        sys_rst    = 1'b1;
        enable     = 1'b1;
        brightness = 4'd15;
        led_in     = 3'b111;
        step(3);
        chk("rst_led_out", 32'(led_out), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        bad = 0;
        repeat (100) begin
            step();
            if (busy !== 1'b0 || led_out !== 3'b111 || dut.duty[0] != 0 ||
                dut.duty[1] != 0 || dut.duty[2] != 0) bad++;
        end
        chk("idle_100", 32'(bad), 32'd0);

        // 2. Fade channel 0 up to full brightness.
        led_in = 3'b110;
        step();
        chk("lat_cycle1_busy", 32'(busy), 32'd0);
        step();
        chk("lat_cycle2_busy", 32'(busy), 32'd1);
        wait_busy("fade_up_done", 1'b0, 80, n);
        chk("fade_up_cycles_in_range", 32'((n + 2 >= 58) && (n + 2 <= 63)), 32'd1);
        chk("fade_up_duty0", 32'(dut.duty[0]), 32'd15);
        lit_count(0, lit, others);
        chk("fade_up_lit0", 32'(lit), 32'd15);
        chk("fade_up_others_dark", 32'(others), 32'd0);

        // 3. Rotate 110 -> 101: crossfade on the same ticks.
        led_in = 3'b101;
        bad = 0;
        n = 0;
        seen = 1'b0;
        while (!(seen && busy === 1'b0) && n < 150) begin
            step();
            n++;
            if (busy === 1'b1) seen = 1'b1;
            if (int'(dut.duty[0]) + int'(dut.duty[1]) != 15) bad++;
        end
        chk("rot_seen_busy", 32'(seen), 32'd1);
        chk("rot_sum_15", 32'(bad), 32'd0);
        chk("rot_busy_clear", 32'(busy), 32'd0);
        chk("rot_duty0", 32'(dut.duty[0]), 32'd0);
        chk("rot_duty1", 32'(dut.duty[1]), 32'd15);

        // 4. Reverse mid-fade at duty 7.
        led_in = 3'b111;
        wait_busy("rev_prep_busy", 1'b1, 5, n);
        wait_busy("rev_prep_idle", 1'b0, 100, n);
        led_in = 3'b110;
        wait_duty0("rev_reach7", 7, 60);
        led_in = 3'b111;
        n = 0;
        while (int'(dut.duty[0]) == 7 && n < 10) begin
            step();
            n++;
        end
        chk("rev_first_step", 32'(dut.duty[0]), 32'd6);
        prev = 6;
        bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            step();
            n++;
            if (int'(dut.duty[0]) > prev || prev - int'(dut.duty[0]) > 1) bad++;
            prev = int'(dut.duty[0]);
        end
        chk("rev_monotonic", 32'(bad), 32'd0);
        chk("rev_busy_clear", 32'(busy), 32'd0);
        chk("rev_duty0_zero", 32'(dut.duty[0]), 32'd0);

        // 5. Lower brightness on a settled lit channel.
        led_in = 3'b110;
        wait_busy("dim_prep_busy", 1'b1, 5, n);
        wait_busy("dim_prep_idle", 1'b0, 80, n);
        chk("dim_prep_duty0", 32'(dut.duty[0]), 32'd15);
        brightness = 4'd8;
        changes = 0;
        prev = 15;
        seen = 1'b0;
        n = 0;
        while (!(seen && busy === 1'b0) && n < 60) begin
            step();
            n++;
            if (busy === 1'b1) seen = 1'b1;
            if (int'(dut.duty[0]) != prev) changes++;
            prev = int'(dut.duty[0]);
        end
        chk("dim_ticks", 32'(changes), 32'd7);
        chk("dim_duty0", 32'(dut.duty[0]), 32'd8);
        lit_count(0, lit, others);
        chk("dim_lit0", 32'(lit), 32'd8);

        // 6. Disable mid-fade, re-enable, then reset on a step tick.
        brightness = 4'd15;
        step(10);
        chk("dis_prep_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        step();
        chk("dis_led_out", 32'(led_out), 32'd7);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_duty0", 32'(dut.duty[0]), 32'd0);
        p = int'(dut.pwm_cnt);
        step();
        chk("dis_pwm_runs", 32'(dut.pwm_cnt), 32'((p + 1) % 16));
        bad = 0;
        repeat (20) begin
            step();
            if (busy !== 1'b0 || led_out !== 3'b111 || dut.duty[0] != 0 ||
                dut.step_cnt != 0) bad++;
        end
        chk("dis_hold", 32'(bad), 32'd0);
        enable = 1'b1;
        step(12);
        chk("reen_duty0", 32'(dut.duty[0]), 32'd3);
        chk("reen_busy", 32'(busy), 32'd1);
        n = 0;
        while (int'(dut.step_cnt) != SC - 1 && n < 8) begin
            step();
            n++;
        end
        chk("rst_tick_aligned", 32'(dut.step_cnt), 32'(SC - 1));
        sys_rst = 1'b1;
        step();
        chk("rst_tick_duty0", 32'(dut.duty[0]), 32'd0);
        chk("rst_tick_led_out", 32'(led_out), 32'd7);
        chk("rst_tick_busy", 32'(busy), 32'd0);
        chk("rst_tick_step_cnt", 32'(dut.step_cnt), 32'd0);
        sys_rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
